// File: rtl/multdiv_pkg.sv
// Shared state encoding and iteration constants for the iterative multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MULT_ITERS = 16;
  localparam int DIV_ITERS  = 32;
  localparam int CNT_W      = 6;

endpackage

// File: rtl/booth_recode_r4.sv
// Radix-4 Booth digit recoder: {b[i+1], b[i], b[i-1]} selects 0, +-A or +-2A.
module booth_recode_r4
  import multdiv_pkg::*;
(
  input  logic [2:0]         bits,
  input  logic signed [32:0] mcand,
  output logic [32:0]        pp,
  output logic               neg
);

  logic [32:0] mag;

  // Negative digits come out one's-complemented with neg as the carry-in, so that
  // -2A stays exact for A = -2^31 (+2^32 does not fit in 33 bits).
  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (bits)
      3'b001, 3'b010: mag = mcand;
      3'b011:         mag = {mcand[31:0], 1'b0};
      3'b100: begin
        mag = {mcand[31:0], 1'b0};
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = mcand;
        neg = 1'b1;
      end
      default:        mag = '0;
    endcase
    pp = neg ? ~mag : mag;
  end

endmodule

// File: rtl/multdiv.sv
// Iterative signed 32-bit multiplier (radix-4 Booth, 16 steps) and restoring divider (32 steps).
module multdiv
  import multdiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic signed [32:0] mcand;
  logic [65:0]        booth;      // {acc[32:0], mplr[31:0], q-1}
  logic [31:0]        rem, quo, dvsr;
  logic               q_neg, div_ovf;

  logic               start, div_zero, load_out, exc_next;
  logic [31:0]        res_next;

  assign start    = ctrl_MULT | ctrl_DIV;
  assign div_zero = ctrl_DIV & ~ctrl_MULT & (data_operandB == 32'd0);

  // Booth step: add the recoded digit to acc in 34 bits, then arithmetic shift right by 2
  logic [32:0] pp;
  logic        pp_neg;
  logic [33:0] acc_sum;
  logic [65:0] booth_step;
  logic [31:0] prod_lo, prod_hi;
  logic        mult_ovf;

  booth_recode_r4 u_recode (
    .bits  (booth[2:0]),
    .mcand (mcand),
    .pp    (pp),
    .neg   (pp_neg)
  );

  assign acc_sum    = {booth[65], booth[65:33]} + {pp[32], pp} + 34'(pp_neg);
  assign booth_step = {acc_sum[33], acc_sum, booth[32:2]};
  assign prod_lo    = booth_step[32:1];
  assign prod_hi    = booth_step[64:33];
  assign mult_ovf   = (prod_hi != {32{prod_lo[31]}});

  // Restoring divide step on magnitudes
  logic [32:0] rem_sh, trial;
  logic [31:0] rem_step, quo_step, div_q;

  assign rem_sh   = {rem, quo[31]};
  assign trial    = rem_sh - {1'b0, dvsr};
  assign rem_step = trial[32] ? rem_sh[31:0] : trial[31:0];
  assign quo_step = {quo[30:0], ~trial[32]};
  assign div_q    = q_neg ? (~quo_step + 32'd1) : quo_step;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_out   = 1'b0;
    res_next   = '0;
    exc_next   = 1'b0;
    if (start) begin
      cnt_next = '0;
      if (ctrl_MULT) begin
        state_next = MULT;
      end else if (div_zero) begin
        state_next = DONE;
        load_out   = 1'b1;
        exc_next   = 1'b1;
      end else begin
        state_next = DIV;
      end
    end else begin
      case (state)
        MULT: begin
          cnt_next = cnt + CNT_W'(1);
          if (cnt == CNT_W'(MULT_ITERS - 1)) begin
            state_next = DONE;
            load_out   = 1'b1;
            res_next   = prod_lo;
            exc_next   = mult_ovf;
          end
        end
        DIV: begin
          cnt_next = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DIV_ITERS - 1)) begin
            state_next = DONE;
            load_out   = 1'b1;
            res_next   = div_q;
            exc_next   = div_ovf;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load_out) begin
        data_result    <= res_next;
        data_exception <= exc_next;
      end
    end
  end

  // Datapath registers carry no reset; the FSM decides when their contents matter
  always_ff @(posedge clock) begin
    if (start && !reset) begin
      mcand   <= {data_operandA[31], data_operandA};
      booth   <= {33'd0, data_operandB, 1'b0};
      rem     <= '0;
      quo     <= mag32(data_operandA);
      dvsr    <= mag32(data_operandB);
      q_neg   <= data_operandA[31] ^ data_operandB[31];
      div_ovf <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
    end else begin
      if (state == MULT) booth <= booth_step;
      if (state == DIV) begin
        rem <= rem_step;
        quo <= quo_step;
      end
    end
  end

  assign data_resultRDY = (state == DONE);

endmodule

// File: tb/tb_multdiv.sv
// Self-checking bench for multdiv: directed spec cases plus randomized operands against an arithmetic model.
module tb_multdiv;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  always #5 clock = ~clock;

  multdiv dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain signed 64-bit arithmetic
  function automatic void model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mult) begin
      p = sa * sb;
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      p = sa / sb;
      r = p[31:0];
      e = 1'b0;
    end
  endfunction

  // Drives a start pulse in cycle 0; returns #1 into cycle 1 with scrambled operands.
  task automatic start_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
    @(posedge clock); #1;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = is_mult;
    ctrl_DIV      = !is_mult;
    @(posedge clock); #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Returns the cycle number of the first ready pulse, or -1 after 60 cycles.
  task automatic wait_rdy(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (data_result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", data_result); end
    n_checks++;
    if (data_exception !== 1'b0) begin n_fail++; $display("FAIL reset_exception got %b want 0", data_exception); end
    n_checks++;
    if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
    // Start controls while reset is high must be ignored
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd5;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; reset = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      n_checks++;
      if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset_priority cycle %0d rdy got %b want 0", c, data_resultRDY); end
    end
  endtask

  task automatic test_mult_directed;
    start_op(1'b1, 32'd7, 32'hFFFF_FFFD);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clock);
      n_checks++;
      if (data_resultRDY !== (c == 17)) begin
        n_fail++; $display("FAIL mult_7x-3_rdy cycle %0d got %b want %b", c, data_resultRDY, (c == 17));
      end
      if (c == 17) begin
        n_checks++;
        if (data_result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_7x-3_result got %h want ffffffeb", data_result); end
        n_checks++;
        if (data_exception !== 1'b0) begin n_fail++; $display("FAIL mult_7x-3_exc got %b want 0", data_exception); end
      end
    end
    begin
      int cyc;
      start_op(1'b1, 32'h0001_0000, 32'h0001_0000);
      wait_rdy(cyc);
      n_checks++;
      if (cyc !== 17) begin n_fail++; $display("FAIL mult_ovf_latency got %0d want 17", cyc); end
      n_checks++;
      if (data_result !== 32'd0) begin n_fail++; $display("FAIL mult_ovf_result got %h want 0", data_result); end
      n_checks++;
      if (data_exception !== 1'b1) begin n_fail++; $display("FAIL mult_ovf_exc got %b want 1", data_exception); end
    end
  endtask

  task automatic test_mult_random;
    logic [31:0] ea[8] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                           32'h7FFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_0000};
    logic [31:0] eb[8] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF,
                           32'h7FFF_FFFF, 32'h0001_0000, 32'h0000_8000, 32'h1234_5678};
    logic [31:0] a, b, er;
    logic        ee;
    int          cyc;
    for (int i = 0; i < 20; i++) begin
      if (i < 8) begin a = ea[i]; b = eb[i]; end
      else if (i < 14) begin a = $urandom; b = $urandom; end
      else begin a = 32'($signed(16'($urandom))); b = 32'($signed(16'($urandom))); end
      model(1'b1, a, b, er, ee);
      start_op(1'b1, a, b);
      wait_rdy(cyc);
      n_checks++;
      if (cyc !== 17) begin n_fail++; $display("FAIL mult_rand_latency %h*%h got %0d want 17", a, b, cyc); end
      n_checks++;
      if (data_result !== er) begin n_fail++; $display("FAIL mult_rand_result %h*%h got %h want %h", a, b, data_result, er); end
      n_checks++;
      if (data_exception !== ee) begin n_fail++; $display("FAIL mult_rand_exc %h*%h got %b want %b", a, b, data_exception, ee); end
    end
  endtask

  task automatic test_div;
    logic [31:0] ea[8] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                           32'd100,      32'hFFFF_FF9C, 32'd3,        32'h8000_0000};
    logic [31:0] eb[8] = '{32'd2,        32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF,
                           32'd7,        32'hFFFF_FFF9, 32'd10,       32'h8000_0000};
    logic [31:0] a, b, er;
    logic        ee;
    int          cyc;
    for (int i = 0; i < 18; i++) begin
      if (i < 8) begin a = ea[i]; b = eb[i]; end
      else begin
        a = $urandom;
        b = (i % 2 == 0) ? 32'($urandom) : 32'($signed(12'($urandom_range(1, 4095))));
        if (b == 32'd0) b = 32'd9;
      end
      model(1'b0, a, b, er, ee);
      start_op(1'b0, a, b);
      wait_rdy(cyc);
      n_checks++;
      if (cyc !== 33) begin n_fail++; $display("FAIL div_latency %h/%h got %0d want 33", a, b, cyc); end
      n_checks++;
      if (data_result !== er) begin n_fail++; $display("FAIL div_result %h/%h got %h want %h", a, b, data_result, er); end
      n_checks++;
      if (data_exception !== ee) begin n_fail++; $display("FAIL div_exc %h/%h got %b want %b", a, b, data_exception, ee); end
    end
  endtask

  task automatic test_div_zero;
    start_op(1'b0, 32'd5, 32'd0);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      n_checks++;
      if (data_resultRDY !== (c == 1)) begin
        n_fail++; $display("FAIL divzero_rdy cycle %0d got %b want %b", c, data_resultRDY, (c == 1));
      end
      if (c == 1 || c == 40) begin
        n_checks++;
        if (data_result !== 32'd0) begin n_fail++; $display("FAIL divzero_result cycle %0d got %h want 0", c, data_result); end
        n_checks++;
        if (data_exception !== 1'b1) begin n_fail++; $display("FAIL divzero_exc cycle %0d got %b want 1", c, data_exception); end
      end
    end
  endtask

  task automatic test_restart;
    start_op(1'b1, 32'd3, 32'd4);
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) begin
        data_operandA = 32'd100; data_operandB = 32'd7; ctrl_DIV = 1'b1;
      end else begin
        ctrl_DIV = 1'b0;
      end
      @(negedge clock);
      n_checks++;
      if (data_resultRDY !== (c == 38)) begin
        n_fail++; $display("FAIL restart_rdy cycle %0d got %b want %b", c, data_resultRDY, (c == 38));
      end
      if (c == 38) begin
        n_checks++;
        if (data_result !== 32'd14) begin n_fail++; $display("FAIL restart_result got %h want 0000000e", data_result); end
        n_checks++;
        if (data_exception !== 1'b0) begin n_fail++; $display("FAIL restart_exc got %b want 0", data_exception); end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    start_op(1'b1, 32'h0000_1234, 32'h0000_5678);
    for (int c = 1; c <= 40; c++) begin
      reset = (c == 10);
      @(negedge clock);
      n_checks++;
      if (c >= 11) begin
        if ({data_resultRDY, data_exception, data_result} !== 34'd0) begin
          n_fail++; $display("FAIL midreset_outputs cycle %0d got rdy=%b exc=%b res=%h want all 0",
                             c, data_resultRDY, data_exception, data_result);
        end
      end else if (data_resultRDY !== 1'b0) begin
        n_fail++; $display("FAIL midreset_rdy cycle %0d got %b want 0", c, data_resultRDY);
      end
      @(posedge clock); #1;
    end
    reset = 1'b0;
    start_op(1'b1, 32'd2, 32'd2);
    wait_rdy(cyc);
    n_checks++;
    if (cyc !== 17) begin n_fail++; $display("FAIL postreset_latency got %0d want 17", cyc); end
    n_checks++;
    if (data_result !== 32'd4) begin n_fail++; $display("FAIL postreset_result got %h want 4", data_result); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b, er1, er2;
    logic        ee1, ee2;
    a = $urandom; b = $urandom;
    model(1'b1, a, b, er1, ee1);
    model(1'b0, 32'd1000, 32'hFFFF_FFF6, er2, ee2);
    start_op(1'b1, a, b);
    for (int c = 1; c <= 55; c++) begin
      if (c == 17) begin
        data_operandA = 32'd1000; data_operandB = 32'hFFFF_FFF6; ctrl_DIV = 1'b1;
      end else begin
        ctrl_DIV = 1'b0;
      end
      @(negedge clock);
      n_checks++;
      if (data_resultRDY !== (c == 17 || c == 50)) begin
        n_fail++; $display("FAIL b2b_rdy cycle %0d got %b want %b", c, data_resultRDY, (c == 17 || c == 50));
      end
      if (c == 17) begin
        n_checks++;
        if (data_result !== er1 || data_exception !== ee1) begin
          n_fail++; $display("FAIL b2b_mult got %h/%b want %h/%b", data_result, data_exception, er1, ee1);
        end
      end
      if (c == 50) begin
        n_checks++;
        if (data_result !== er2 || data_exception !== ee2) begin
          n_fail++; $display("FAIL b2b_div got %h/%b want %h/%b", data_result, data_exception, er2, ee2);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    test_reset;
    test_mult_directed;
    test_mult_random;
    test_div;
    test_div_zero;
    test_restart;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv.md
# multdiv

Iterative signed 32-bit multiply/divide unit for the processor's execute stage. Starts on a one-cycle `ctrl_MULT` or `ctrl_DIV` pulse and runs for a fixed number of cycles. It then presents `data_result`, `data_exception` and a one-cycle `data_resultRDY` pulse. `data_result` feeds one input of the execute-stage 8:1 32-bit result-select mux; the pipeline stalls on this unit until `data_resultRDY`.

## Interface
- Parameters: none. Data width is fixed at 32.
- `clock`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high.
- `data_operandA`  in  32  — multiplicand or dividend (two's complement); sampled on the start edge only.
- `data_operandB`  in  32  — multiplier or divisor (two's complement); sampled on the start edge only.
- `ctrl_MULT`  in  1  — start pulse for a multiply.
- `ctrl_DIV`  in  1  — start pulse for a divide.
- `data_result`  out  32  — low 32 bits of the product, or the quotient.
- `data_exception`  out  1  — signals multiply overflow, divide by zero, or `0x80000000 / -1`.
- `data_resultRDY`  out  1  — one-cycle pulse when `data_result` and `data_exception` are valid.

## Operation
- **States:**
  - `IDLE`
  - `MULT` — 16 iterations, radix-4 Booth.
  - `DIV` — 32 iterations, restoring divide on magnitudes.
  - `DONE` — one cycle, asserts `data_resultRDY`.
  - `DONE` always returns to `IDLE`.
- **Start:** `ctrl_MULT` or `ctrl_DIV` high on an edge starts an operation, in any state.
  - Operands and op are latched.
  - The iteration counter clears.
  - Any in-flight operation is abandoned with no `data_resultRDY` for it.
  - If both controls are high, MULT wins.
- **MULT:**
  - Internal state is a 66-bit `{acc[32:0], mplr[31:0], q-1}` register with a 33-bit sign-extended multiplicand.
  - Each iteration recodes 3 bits to a digit in {0, ±A, ±2A}, adds it to `acc`, and arithmetic-shifts right by 2.
  - After 16 iterations, `data_result` = product[31:0].
  - `data_exception` = 1 iff the full 64-bit product is not the sign extension of product[31:0].
- **DIV:**
  - Operates on the magnitudes |A| and |B|.
  - Each iteration: shift `{rem, quo}` left 1, trial-subtract |B|, restore if negative, and set the quotient bit.
  - The quotient is negated if sign(A) XOR sign(B). The result truncates toward zero; the remainder is discarded.
- **Divide by zero (B == 0):**
  - Detected on the start edge. The unit goes straight to `DONE`.
  - Outputs: `data_result` = 0, `data_exception` = 1.
- **A = `0x80000000`, B = `0xFFFFFFFF`:** runs the full 32 iterations, then outputs `data_result` = `0x80000000`, `data_exception` = 1.
- **Output hold:** `data_result` and `data_exception` are registered. They update only on the edge entering `DONE` and hold until the next `DONE`.
- **Reset:**
  - Reset forces `IDLE`, counter 0, `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0.
  - Reset mid-operation abandons the operation, with no `data_resultRDY` pulse.
  - Reset has priority over start.

## Timing
- Cycle numbering: the cycle in which the start control is high is cycle 0; it is sampled on the edge ending cycle 0.
- `data_resultRDY` is high for exactly one cycle:
  - Multiply: cycle 17.
  - Divide: cycle 33.
  - Divide by zero: cycle 1.
- A new start in cycle k re-times the operation: the next `data_resultRDY` falls in cycle k+17 or k+33 (k+1 for divide by zero).
- A start in the `DONE` cycle is legal. The current pulse still completes, and the new operation begins.
- Control inputs are ignored while `reset` is high.
- Operand changes after cycle 0 have no effect.

## Structure
- Shared package `multdiv_pkg`:
  - State encoding: `IDLE`, `MULT`, `DIV`, `DONE`.
  - Constants: `MULT_ITERS = 16`, `DIV_ITERS = 32`, `CNT_W = 6`.
- One natural sub-module: `booth_recode_r4`.
  - Maps 3 multiplier bits plus the 33-bit multiplicand to a 33-bit signed partial product (0, ±A, ±2A).
  - Purely combinational.
- The FSM, counter, datapath registers and sign fix-up live in `multdiv`.

## Test plan
- MULT, A = 7, B = −3 (`0xFFFFFFFD`) → cycle 17: `data_resultRDY` = 1, `data_result` = `0xFFFFFFEB`, `data_exception` = 0; `data_resultRDY` low in cycles 1–16 and 18.
- MULT, A = `0x00010000`, B = `0x00010000` → cycle 17: `data_result` = `0x00000000`, `data_exception` = 1.
- DIV, A = −7, B = 2 → cycle 33: `data_result` = `0xFFFFFFFD`, `data_exception` = 0; DIV, A = `0x80000000`, B = −1 → cycle 33: `data_result` = `0x80000000`, `data_exception` = 1.
- DIV, A = 5, B = 0 → cycle 1: `data_resultRDY` = 1, `data_result` = 0, `data_exception` = 1; no further pulse.
- MULT 3×4 started in cycle 0, DIV 100/7 started in cycle 5 → single `data_resultRDY` in cycle 38 with `data_result` = 14; no pulse in cycle 17.
- MULT started, `reset` high in cycle 10 → all outputs 0 from cycle 11, no `data_resultRDY` through cycle 40; a fresh MULT 2×2 afterwards returns 4 after 17 cycles.
